// File: rtl/window_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_reduce_pkg
// Purpose  : Shared mode encodings and FSM state encoding for window_reduce.
// Revision : 1.0 - initial release
// ============================================================================
package window_reduce_pkg;

  // Reduction select; 2'b11 is reserved and decoded as max.
  localparam logic [1:0] MODE_MAX  = 2'b00;
  localparam logic [1:0] MODE_MIN  = 2'b01;
  localparam logic [1:0] MODE_MEAN = 2'b10;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_DIVIDE = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seq_udiv.sv
`default_nettype none
// ============================================================================
// Module   : seq_udiv
// Purpose  : Serial restoring divider by a constant. One quotient bit per
//            cycle, DW cycles in total; the first bit is resolved in the
//            start cycle so done pulses DW-1 cycles after start.
// Revision : 1.0 - initial release
// ============================================================================
module seq_udiv #(
  parameter int DW      = 13,
  parameter int DIVISOR = 25,
  parameter int QW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int          CW    = $clog2(DW);
  localparam logic [DW:0] DIV_C = (DW+1)'(DIVISOR);

  logic [DW-1:0] rem;
  logic [DW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          busy;

  logic [DW-1:0] src_rem;
  logic [DW-1:0] src_quo;
  logic [DW:0]   shifted;
  logic          ge;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] quo_nxt;

  // One restoring step; on start the step works on the fresh dividend.
  always_comb begin
    src_rem = start ? '0 : rem;
    src_quo = start ? dividend : quo;
    shifted = {src_rem, src_quo[DW-1]};
    ge      = (shifted >= DIV_C);
    // Partial remainder stays below the divisor, so the top bit is always 0.
    rem_nxt = ge ? DW'(shifted - DIV_C) : DW'(shifted);
    quo_nxt = {src_quo[DW-2:0], ge};
  end

  // Iteration registers: load+first step on start, then DW-1 more steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= rem_nxt;
        quo  <= quo_nxt;
        cnt  <= CW'(DW-1);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo[QW-1:0];

endmodule
`default_nettype wire

// File: rtl/window_reduce.sv
`default_nettype none
// ============================================================================
// Module   : window_reduce
// Purpose  : Reduces each window of N unsigned elements to its max, min or
//            floor mean, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module window_reduce
  import window_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int SUM_W = WIDTH + $clog2(N);
  localparam int CNT_W = $clog2(N+1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;

  logic             accept;
  logic             last;
  logic [SUM_W-1:0] in_ext;
  logic [SUM_W-1:0] sum_next;
  logic [WIDTH-1:0] new_max;
  logic [WIDTH-1:0] new_min;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_q;

  assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign accept    = in_valid && in_ready;
  assign last      = (state == ST_ACCUM) && (count == CNT_W'(N-1));
  assign in_ext    = {{(SUM_W-WIDTH){1'b0}}, in_data};
  assign sum_next  = sum + in_ext;
  assign new_max   = (in_data > max_q) ? in_data : max_q;
  assign new_min   = (in_data < min_q) ? in_data : min_q;
  // The divider takes the final sum straight from the adder on the Nth accept.
  assign div_start = accept && last && (mode_q == MODE_MEAN);

  seq_udiv #(
    .DW      (SUM_W),
    .DIVISOR (N),
    .QW      (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_next),
    .done     (div_done),
    .quotient (div_q)
  );

  // Window FSM with running max/min/sum and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= 2'b00;
      count     <= '0;
      sum       <= '0;
      max_q     <= '0;
      min_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q <= mode;
            max_q  <= in_data;
            min_q  <= in_data;
            sum    <= in_ext;
            count  <= CNT_W'(1);
            state  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            max_q <= new_max;
            min_q <= new_min;
            sum   <= sum_next;
            count <= count + CNT_W'(1);
            if (last) begin
              if (mode_q == MODE_MEAN) begin
                state <= ST_DIVIDE;
              end else begin
                state     <= ST_OUTPUT;
                out_valid <= 1'b1;
                out_data  <= (mode_q == MODE_MIN) ? new_min : new_max;
              end
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            state     <= ST_OUTPUT;
            out_valid <= 1'b1;
            out_data  <= div_q;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_reduce
// Purpose  : Directed self-checking bench for window_reduce (WIDTH=8, N=25).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_reduce;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] vals [25];

  window_reduce #(.WIDTH(8), .N(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic fill_ramp;
    for (int i = 0; i < 25; i++) vals[i] = 8'(i + 1);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 25; i++) vals[i] = v;
  endtask

  // Streams n_elem elements (inputs change on negedge), then waits up to
  // max_wait cycles for out_valid. lat = cycles after the last acceptance
  // edge at which out_valid is first seen (1 = next cycle), -1 if never.
  task automatic run_window(input logic [1:0] m0, input int sw_idx,
                            input logic [1:0] m1, input int n_elem,
                            input int gap, input int max_wait,
                            output int lat, output logic [7:0] res);
    out_ready = 1'b0;
    for (int i = 0; i < n_elem; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vals[i];
      mode     = (i >= sw_idx) ? m1 : m0;
      @(posedge clk);
      if (gap > 0 && i < n_elem - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
      end
    end
    lat = -1;
    for (int k = 1; k <= max_wait; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = out_data;
  endtask

  task automatic finish_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max;
    int lat;
    logic [7:0] res;
    fill_ramp();
    run_window(2'b00, 99, 2'b00, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd25) $display("FAIL max_data: got %0d expected 25", res);
    else pass_cnt++;
    total_cnt++;
    if (lat != 1) $display("FAIL max_latency: got %0d expected 1", lat);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL max_in_ready_output: got %b expected 0", in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL max_after_handshake: got valid=%b ready=%b expected valid=0 ready=1",
               out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_min;
    int lat;
    logic [7:0] res;
    fill_ramp();
    run_window(2'b01, 99, 2'b01, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd1 || lat != 1) $display("FAIL min_ramp: got data=%0d lat=%0d expected data=1 lat=1", res, lat);
    else pass_cnt++;
    finish_out();
  endtask

  task automatic test_mean;
    int lat;
    logic [7:0] res;
    fill_ramp();
    run_window(2'b10, 99, 2'b10, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd13) $display("FAIL mean_data: got %0d expected 13", res);
    else pass_cnt++;
    total_cnt++;
    if (lat != 14) $display("FAIL mean_latency: got %0d expected 14", lat);
    else pass_cnt++;
    finish_out();
  endtask

  task automatic test_mean_bounds;
    int lat;
    logic [7:0] res;
    fill_const(8'd255);
    run_window(2'b10, 99, 2'b10, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd255) $display("FAIL mean_all_255: got %0d expected 255", res);
    else pass_cnt++;
    finish_out();
    fill_const(8'd0);
    vals[24] = 8'd24;
    run_window(2'b10, 99, 2'b10, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd0 || lat != 14) $display("FAIL mean_truncate: got data=%0d lat=%0d expected data=0 lat=14", res, lat);
    else pass_cnt++;
    finish_out();
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    int hs;
    logic [7:0] res;
    fill_ramp();
    run_window(2'b00, 99, 2'b00, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd25) $display("FAIL bp_data: got %0d expected 25", res);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'd25 || in_ready !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
    else pass_cnt++;
    out_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) hs++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    total_cnt++;
    if (hs != 1) $display("FAIL bp_handshakes: got %0d expected 1", hs);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [7:0] res;
    // Abort a partial window.
    fill_const(8'd200);
    run_window(2'b10, 99, 2'b10, 10, 0, 2, lat, res);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_window_state: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    fill_const(8'd7);
    run_window(2'b10, 99, 2'b10, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd7 || lat != 14) $display("FAIL rst_mid_window_mean: got data=%0d lat=%0d expected data=7 lat=14", res, lat);
    else pass_cnt++;
    finish_out();
    // Abort a division in progress.
    fill_const(8'd200);
    run_window(2'b10, 99, 2'b10, 25, 0, 5, lat, res);
    total_cnt++;
    if (lat != -1) $display("FAIL rst_mid_div_early_valid: got lat=%0d expected -1", lat);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_ramp();
    run_window(2'b10, 99, 2'b10, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd13 || lat != 14) $display("FAIL rst_mid_div_mean: got data=%0d lat=%0d expected data=13 lat=14", res, lat);
    else pass_cnt++;
    finish_out();
  endtask

  task automatic test_mode_switch;
    int lat;
    logic [7:0] res;
    fill_ramp();
    run_window(2'b00, 5, 2'b01, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd25) $display("FAIL switch_max_to_min: got %0d expected 25", res);
    else pass_cnt++;
    finish_out();
    run_window(2'b01, 5, 2'b10, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd1 || lat != 1) $display("FAIL switch_min_to_mean: got data=%0d lat=%0d expected data=1 lat=1", res, lat);
    else pass_cnt++;
    finish_out();
    run_window(2'b11, 99, 2'b11, 25, 0, 40, lat, res);
    total_cnt++;
    if (res !== 8'd25 || lat != 1) $display("FAIL reserved_mode: got data=%0d lat=%0d expected data=25 lat=1", res, lat);
    else pass_cnt++;
    finish_out();
  endtask

  task automatic test_gaps;
    int lat;
    logic [7:0] res;
    fill_ramp();
    run_window(2'b01, 99, 2'b01, 25, 3, 40, lat, res);
    total_cnt++;
    if (res !== 8'd1 || lat != 1) $display("FAIL gaps_min: got data=%0d lat=%0d expected data=1 lat=1", res, lat);
    else pass_cnt++;
    finish_out();
    run_window(2'b10, 99, 2'b10, 25, 3, 40, lat, res);
    total_cnt++;
    if (res !== 8'd13 || lat != 14) $display("FAIL gaps_mean: got data=%0d lat=%0d expected data=13 lat=14", res, lat);
    else pass_cnt++;
    finish_out();
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    mode      = 2'b00;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_max();
    test_min();
    test_mean();
    test_mean_bounds();
    test_backpressure();
    test_reset_mid();
    test_mode_switch();
    test_gaps();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
